// File: rtl/ps2_cmd_sequencer.sv
// PS/2 host command sequencer: sends a command byte (plus optional argument),
// waits for the device ACK after each byte, retries on RESEND/timeout/tx error,
// and forwards received scancodes to user logic only while idle.
module ps2_cmd_sequencer #(
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int MAX_RETRY      = 2
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       cmd_req,
  input  logic [7:0] cmd_byte,
  input  logic       arg_valid,
  input  logic [7:0] arg_byte,
  output logic       cmd_ready,
  output logic       done,
  output logic       err,
  output logic       tx_send,
  output logic [7:0] tx_byte,
  input  logic       tx_busy,
  input  logic       tx_done,
  input  logic       tx_error,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  output logic       key_valid,
  output logic [7:0] key_byte
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int RW = 4;
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [7:0]    ACK_CODE    = 8'hFA;
  localparam logic [7:0]    RESEND_CODE = 8'hFE;

  typedef enum logic [2:0] {
    IDLE, SEND_CMD, WAIT_TXC, WAIT_ACKC, SEND_ARG, WAIT_TXA, WAIT_ACKA, FINISH
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [7:0]      arg_q, arg_d;
  logic            argv_q, argv_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            err_q, err_d;
  logic [7:0]      txb_q, txb_d;
  logic            keyv_q, keyv_d;
  logic [7:0]      keyb_q, keyb_d;
  logic            ack, fail, in_cmd_phase;

  // Next-state logic: handshake with transceiver, ACK wait, retry bookkeeping.
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    arg_d        = arg_q;
    argv_d       = argv_q;
    retry_d      = retry_q;
    timer_d      = timer_q;
    err_d        = err_q;
    txb_d        = txb_q;
    keyv_d       = 1'b0;
    keyb_d       = keyb_q;
    tx_send      = 1'b0;
    ack          = 1'b0;
    fail         = 1'b0;
    in_cmd_phase = (state_q == WAIT_TXC) || (state_q == WAIT_ACKC);

    case (state_q)
      IDLE: begin
        // Scancodes only reach user logic while the port is not owned by a command.
        if (rx_valid) begin
          keyv_d = 1'b1;
          keyb_d = rx_byte;
        end
        if (cmd_req) begin
          cmd_d   = cmd_byte;
          arg_d   = arg_byte;
          argv_d  = arg_valid;
          retry_d = '0;
          err_d   = 1'b0;
          txb_d   = cmd_byte;
          state_d = SEND_CMD;
        end
      end
      SEND_CMD, SEND_ARG: begin
        if (!tx_busy) begin
          tx_send = 1'b1;
          state_d = (state_q == SEND_CMD) ? WAIT_TXC : WAIT_TXA;
        end
      end
      WAIT_TXC, WAIT_TXA: begin
        if (tx_done) begin
          timer_d = '0;
          state_d = (state_q == WAIT_TXC) ? WAIT_ACKC : WAIT_ACKA;
        end else if (tx_error) begin
          fail = 1'b1;
        end
      end
      WAIT_ACKC, WAIT_ACKA: begin
        timer_d = timer_q + TW'(1);
        // ACK is checked first so an ACK landing on the timeout cycle still counts.
        if (rx_valid && (rx_byte == ACK_CODE)) begin
          ack = 1'b1;
        end else if (rx_valid && (rx_byte == RESEND_CODE)) begin
          fail = 1'b1;
        end else if (timer_q == TMO_LAST) begin
          fail = 1'b1;
        end
        if (ack) begin
          if ((state_q == WAIT_ACKC) && argv_q) begin
            txb_d   = arg_q;
            state_d = SEND_ARG;
          end else begin
            err_d   = 1'b0;
            state_d = FINISH;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A failed byte is resent as-is (txb unchanged); the retry budget spans the whole transaction.
    if (fail) begin
      if (retry_q < RETRY_MAX) begin
        retry_d = retry_q + RW'(1);
        state_d = in_cmd_phase ? SEND_CMD : SEND_ARG;
      end else begin
        err_d   = 1'b1;
        state_d = FINISH;
      end
    end
  end

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      arg_q   <= '0;
      argv_q  <= 1'b0;
      retry_q <= '0;
      timer_q <= '0;
      err_q   <= 1'b0;
      txb_q   <= '0;
      keyv_q  <= 1'b0;
      keyb_q  <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      arg_q   <= arg_d;
      argv_q  <= argv_d;
      retry_q <= retry_d;
      timer_q <= timer_d;
      err_q   <= err_d;
      txb_q   <= txb_d;
      keyv_q  <= keyv_d;
      keyb_q  <= keyb_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign done      = (state_q == FINISH);
  assign err       = err_q;
  assign tx_byte   = txb_q;
  assign key_valid = keyv_q;
  assign key_byte  = keyb_q;

endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
// Directed bench for ps2_cmd_sequencer: drives the transceiver/device side by
// hand and checks sends, ACK handling, retries, timeout, scancode forwarding.
module tb_ps2_cmd_sequencer;

  localparam int TMO = 120;

  logic       clk;
  logic       resetn;
  logic       cmd_req;
  logic [7:0] cmd_byte;
  logic       arg_valid;
  logic [7:0] arg_byte;
  logic       cmd_ready;
  logic       done;
  logic       err;
  logic       tx_send;
  logic [7:0] tx_byte;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       key_valid;
  logic [7:0] key_byte;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         sends   = 0;
  int         dones   = 0;
  int         keys    = 0;
  int         busy_viol = 0;
  logic [7:0] log_b [0:63];
  logic       last_err = 1'b0;
  logic [7:0] last_key = 8'h00;

  ps2_cmd_sequencer #(.TIMEOUT_CYCLES(TMO), .MAX_RETRY(2)) dut (
    .CLOCK_50(clk), .resetn(resetn),
    .cmd_req(cmd_req), .cmd_byte(cmd_byte), .arg_valid(arg_valid), .arg_byte(arg_byte),
    .cmd_ready(cmd_ready), .done(done), .err(err),
    .tx_send(tx_send), .tx_byte(tx_byte), .tx_busy(tx_busy),
    .tx_done(tx_done), .tx_error(tx_error),
    .rx_valid(rx_valid), .rx_byte(rx_byte),
    .key_valid(key_valid), .key_byte(key_byte)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor on the falling edge, away from the edge that updates the DUT.
  always @(negedge clk) begin
    if (tx_send) begin
      if (sends < 64) log_b[sends] = tx_byte;
      sends++;
      if (tx_busy) busy_viol++;
    end
    if (done) begin
      dones++;
      last_err = err;
    end
    if (key_valid) begin
      keys++;
      last_key = key_byte;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] c, input logic av, input logic [7:0] a);
    cmd_req = 1'b1; cmd_byte = c; arg_valid = av; arg_byte = a;
    tick(1);
    cmd_req = 1'b0;
  endtask

  task automatic wait_sends(input int target, input int budget, input string tag);
    int c = 0;
    while (sends < target && c < budget) begin
      tick(1);
      c++;
    end
    check(tag, sends, target);
  endtask

  task automatic wait_dones(input int target, input int budget, input string tag);
    int c = 0;
    while (dones < target && c < budget) begin
      tick(1);
      c++;
    end
    check(tag, dones, target);
  endtask

  task automatic tx_ok();
    tx_done = 1'b1;
    tick(1);
    tx_done = 1'b0;
  endtask

  task automatic rx(input logic [7:0] b);
    rx_valid = 1'b1; rx_byte = b;
    tick(1);
    rx_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; cmd_req = 1'b0; cmd_byte = 8'h00; arg_valid = 1'b0; arg_byte = 8'h00;
    tx_busy = 1'b0; tx_done = 1'b0; tx_error = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00;
    tick(3);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_tx_send", tx_send, 0);
    check("rst_tx_byte", tx_byte, 8'h00);
    check("rst_key_valid", key_valid, 0);
    check("rst_key_byte", key_byte, 8'h00);
    resetn = 1'b1;
    tick(1);

    // 1: reset command, ACK after 100 clocks
    issue(8'hFF, 1'b0, 8'h00);
    wait_sends(1, 5, "t1_send");
    check("t1_byte", log_b[0], 8'hFF);
    check("t1_busy_ready", cmd_ready, 0);
    tx_ok();
    tick(100);
    rx(8'hFA);
    wait_dones(1, 5, "t1_done");
    check("t1_err", last_err, 0);
    check("t1_ready", cmd_ready, 1);
    tick(3);
    check("t1_one_pulse", dones, 1);
    check("t1_sends", sends, 1);

    // 2: LED command with argument; a request while busy is ignored
    issue(8'hED, 1'b1, 8'h07);
    wait_sends(2, 5, "t2_send_cmd");
    check("t2_cmd_byte", log_b[1], 8'hED);
    tx_ok();
    issue(8'hAA, 1'b0, 8'h00);
    rx(8'hFA);
    wait_sends(3, 5, "t2_send_arg");
    check("t2_arg_byte", log_b[2], 8'h07);
    tx_ok();
    rx(8'hFA);
    wait_dones(2, 5, "t2_done");
    check("t2_err", last_err, 0);
    tick(10);
    check("t2_no_queue", sends, 3);
    check("t2_dones", dones, 2);

    // 3: transceiver busy holds off the strobe; two RESENDs then ACK
    tx_busy = 1'b1;
    issue(8'hED, 1'b1, 8'h07);
    tick(4);
    check("t3_busy_hold", sends, 3);
    tx_busy = 1'b0;
    wait_sends(4, 5, "t3_send1");
    check("t3_b1", log_b[3], 8'hED);
    tx_ok();
    rx(8'hFE);
    wait_sends(5, 5, "t3_send2");
    check("t3_b2", log_b[4], 8'hED);
    tx_ok();
    rx(8'hFE);
    wait_sends(6, 5, "t3_send3");
    check("t3_b3", log_b[5], 8'hED);
    tx_ok();
    rx(8'hFA);
    wait_sends(7, 5, "t3_send_arg");
    check("t3_arg", log_b[6], 8'h07);
    tx_ok();
    rx(8'hFA);
    wait_dones(3, 5, "t3_done");
    check("t3_err", last_err, 0);

    // 4: no device response -> three timed-out sends, then err
    issue(8'hF4, 1'b0, 8'h00);
    wait_sends(8, 5, "t4_send1");
    check("t4_b1", log_b[7], 8'hF4);
    tx_ok();
    tick(TMO - 1);
    check("t4_no_early", sends, 8);
    tick(2);
    check("t4_timeout1", sends, 9);
    tx_ok();
    tick(TMO - 1);
    check("t4_no_early2", sends, 9);
    tick(2);
    check("t4_timeout2", sends, 10);
    check("t4_b3", log_b[9], 8'hF4);
    tx_ok();
    wait_dones(4, TMO + 5, "t4_done");
    check("t4_err", last_err, 1);
    tick(TMO + 10);
    check("t4_no_4th", sends, 10);
    check("t4_err_held", err, 1);

    // 5: scancode forwarding in IDLE only; ACK on the timeout cycle wins
    rx(8'h1C);
    check("t5_key_valid", key_valid, 1);
    check("t5_key_byte", key_byte, 8'h1C);
    tick(1);
    check("t5_key_pulse", key_valid, 0);
    check("t5_keys", keys, 1);
    issue(8'hF3, 1'b0, 8'h00);
    check("t5_err_cleared", err, 0);
    wait_sends(11, 5, "t5_send");
    check("t5_byte", log_b[10], 8'hF3);
    tx_ok();
    rx(8'h1C);
    tick(TMO - 2);
    rx(8'hFA);
    wait_dones(5, 5, "t5_done");
    check("t5_err", last_err, 0);
    check("t5_no_retry", sends, 11);
    check("t5_no_key_busy", keys, 1);

    // 6: reset during argument ACK wait abandons the transaction
    issue(8'hED, 1'b1, 8'hAB);
    wait_sends(12, 5, "t6_send_cmd");
    check("t6_cmd", log_b[11], 8'hED);
    tx_ok();
    rx(8'hFA);
    wait_sends(13, 5, "t6_send_arg");
    check("t6_arg", log_b[12], 8'hAB);
    tx_ok();
    tick(3);
    resetn = 1'b0;
    tick(1);
    resetn = 1'b1;
    check("t6_ready", cmd_ready, 1);
    tick(TMO + 10);
    check("t6_no_done", dones, 5);
    check("t6_no_send", sends, 13);
    issue(8'hFF, 1'b0, 8'h00);
    wait_sends(14, 5, "t6_new_send");
    check("t6_new_byte", log_b[13], 8'hFF);
    tx_ok();
    rx(8'hFA);
    wait_dones(6, 5, "t6_new_done");
    check("t6_new_err", last_err, 0);

    // 7: tx error on the argument byte resends only the argument
    issue(8'hF0, 1'b1, 8'h02);
    wait_sends(15, 5, "t7_send_cmd");
    check("t7_cmd", log_b[14], 8'hF0);
    tx_ok();
    rx(8'hFA);
    wait_sends(16, 5, "t7_send_arg");
    check("t7_arg", log_b[15], 8'h02);
    tx_error = 1'b1;
    tick(1);
    tx_error = 1'b0;
    wait_sends(17, 5, "t7_resend_arg");
    check("t7_arg_again", log_b[16], 8'h02);
    tx_ok();
    rx(8'hFA);
    wait_dones(7, 5, "t7_done");
    check("t7_err", last_err, 0);

    check("busy_violations", busy_viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
